// File: rtl/qam_demult_sync.sv
// qam_demult_sync: carrier-synchronised QAM demultiplier.
// Buffers qam samples in a FIFO, starts draining on a carrier zero-phase cycle,
// multiplies each sample by cos and -sin through a MULT_LATENCY-deep pipeline
// and produces scaled, optionally rounded, saturated I/Q plus lock/error status.
//
// Ports:
//   axi_clk, axi_rstn        clock, asynchronous active-low reset
//   qam_valid, qam_data      input sample stream (signed IN_WIDTH)
//   car_valid, car_zero      carrier valid / carrier at zero phase this cycle
//   car_sin, car_cos         signed carrier, Q1.(CAR_WIDTH-1)
//   resync_req               pulse: flush FIFO and drop lock
//   clr_flags                pulse: clear sticky fifo_ovf / fifo_unf
//   dm_valid, dm_i, dm_q     output strobe and signed I/Q (held while !dm_valid)
//   locked                   receiver is in RUN
//   fifo_level               current FIFO occupancy
//   fifo_ovf, fifo_unf       sticky overflow / underflow flags
//   sat_flag                 pulse with dm_valid when either channel clamped
module qam_demult_sync #(
  parameter int unsigned IN_WIDTH     = 13,
  parameter int unsigned CAR_WIDTH    = 8,
  parameter int unsigned OUT_WIDTH    = 13,
  parameter int unsigned FIFO_DEPTH   = 64,
  parameter int unsigned MULT_LATENCY = 4,
  parameter int unsigned ROUND_MODE   = 0
) (
  input  logic                           axi_clk,
  input  logic                           axi_rstn,
  input  logic                           qam_valid,
  input  logic signed [IN_WIDTH-1:0]     qam_data,
  input  logic                           car_valid,
  input  logic                           car_zero,
  input  logic signed [CAR_WIDTH-1:0]    car_sin,
  input  logic signed [CAR_WIDTH-1:0]    car_cos,
  input  logic                           resync_req,
  input  logic                           clr_flags,
  output logic                           dm_valid,
  output logic signed [OUT_WIDTH-1:0]    dm_i,
  output logic signed [OUT_WIDTH-1:0]    dm_q,
  output logic                           locked,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic                           fifo_ovf,
  output logic                           fifo_unf,
  output logic                           sat_flag
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LW  = AW + 1;
  localparam int unsigned CW1 = CAR_WIDTH + 1;
  localparam int unsigned PW  = IN_WIDTH + CAR_WIDTH + 1;
  localparam int unsigned SHIFT = CAR_WIDTH - 1;

  localparam logic signed [PW-1:0] RND  = (ROUND_MODE != 0) ? PW'(2 ** (CAR_WIDTH - 2)) : PW'(0);
  localparam logic signed [PW-1:0] OMAX = PW'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] OMIN = PW'(-(2 ** (OUT_WIDTH - 1)));

  typedef enum logic {
    WAIT_ZERO = 1'b0,
    RUN       = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic signed [IN_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic empty_c, full_c;
  logic rd_en_c, wr_en_c;
  logic ovf_set_c, unf_set_c;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic locked_q;

  // Read stage: sample and the carrier of the same cycle registered together
  logic                        s0_v_q;
  logic signed [IN_WIDTH-1:0]  s0_data_q;
  logic signed [CAR_WIDTH-1:0] s0_cos_q;
  logic signed [CW1-1:0]       s0_nsin_q;
  logic signed [CW1-1:0]       nsin_c;

  logic signed [PW-1:0] prod_i_c, prod_q_c;
  logic                 last_v;
  logic signed [PW-1:0] last_pi, last_pq;
  logic [OUT_WIDTH:0]   si_c, sq_c;

  logic                        dm_valid_q;
  logic signed [OUT_WIDTH-1:0] dm_i_q, dm_q_q;
  logic                        sat_q;

  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == LW'(FIFO_DEPTH));

  // Next-state, FIFO control and flag logic
  always_comb begin
    state_d   = state_q;
    rd_en_c   = 1'b0;
    wr_en_c   = 1'b0;
    ovf_set_c = 1'b0;
    unf_set_c = 1'b0;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;

    rd_en_c   = car_valid && !empty_c &&
                ((state_q == RUN) || ((state_q == WAIT_ZERO) && car_zero));
    wr_en_c   = qam_valid && (!full_c || rd_en_c) && !resync_req;
    ovf_set_c = qam_valid && full_c && !rd_en_c && !resync_req;
    unf_set_c = (state_q == RUN) && car_valid && empty_c;

    case (state_q)
      WAIT_ZERO: if (car_valid && car_zero && !empty_c) state_d = RUN;
      RUN:       if (!car_valid || empty_c) state_d = WAIT_ZERO;
    endcase

    if (wr_en_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en_c) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_en_c && !rd_en_c)      count_d = count_q + LW'(1);
    else if (!wr_en_c && rd_en_c) count_d = count_q - LW'(1);

    // Flush overrides any FIFO movement and lock this cycle
    if (resync_req) begin
      state_d  = WAIT_ZERO;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    // A new event in the same cycle beats a clear
    if (clr_flags) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (ovf_set_c) ovf_d = 1'b1;
    if (unf_set_c) unf_d = 1'b1;
  end

  // State, pointers, flags
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state_q  <= WAIT_ZERO;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      locked_q <= (state_d == RUN);
    end
  end

  // Sample storage; contents are don't-care until written
  always_ff @(posedge axi_clk) begin
    if (wr_en_c) mem_q[wr_ptr_q] <= qam_data;
  end

  // -sin at CAR_WIDTH+1 bits so negating the most negative sine is exact
  assign nsin_c = -CW1'(car_sin);

  // Read stage
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      s0_v_q    <= 1'b0;
      s0_data_q <= '0;
      s0_cos_q  <= '0;
      s0_nsin_q <= '0;
    end else begin
      s0_v_q <= rd_en_c;
      if (rd_en_c) begin
        s0_data_q <= mem_q[rd_ptr_q];
        s0_cos_q  <= car_cos;
        s0_nsin_q <= nsin_c;
      end
    end
  end

  // Full-precision products; PW bits hold every product exactly
  assign prod_i_c = PW'(s0_data_q) * PW'(s0_cos_q);
  assign prod_q_c = PW'(s0_data_q) * PW'(s0_nsin_q);

  // MULT_LATENCY-1 product stages; the output register is the final stage
  generate
    if (MULT_LATENCY == 1) begin : g_direct
      assign last_v  = s0_v_q;
      assign last_pi = prod_i_c;
      assign last_pq = prod_q_c;
    end else begin : g_pipe
      localparam int unsigned NS = MULT_LATENCY - 1;
      logic [NS-1:0]        v_q;
      logic signed [PW-1:0] pi_q [NS];
      logic signed [PW-1:0] pq_q [NS];

      always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
          v_q <= '0;
          for (int k = 0; k < int'(NS); k++) begin
            pi_q[k] <= '0;
            pq_q[k] <= '0;
          end
        end else begin
          v_q[0]  <= s0_v_q;
          pi_q[0] <= prod_i_c;
          pq_q[0] <= prod_q_c;
          for (int k = 1; k < int'(NS); k++) begin
            v_q[k]  <= v_q[k-1];
            pi_q[k] <= pi_q[k-1];
            pq_q[k] <= pq_q[k-1];
          end
        end
      end

      assign last_v  = v_q[NS-1];
      assign last_pi = pi_q[NS-1];
      assign last_pq = pq_q[NS-1];
    end
  endgenerate

  // Round (optional), arithmetic shift, clamp; MSB of result flags saturation
  function automatic logic [OUT_WIDTH:0] scale_sat(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] r;
    r = (p + RND) >>> SHIFT;
    if (r > OMAX) return {1'b1, OMAX[OUT_WIDTH-1:0]};
    if (r < OMIN) return {1'b1, OMIN[OUT_WIDTH-1:0]};
    return {1'b0, r[OUT_WIDTH-1:0]};
  endfunction

  assign si_c = scale_sat(last_pi);
  assign sq_c = scale_sat(last_pq);

  // Output stage; I/Q hold their last value between strobes
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      dm_valid_q <= 1'b0;
      dm_i_q     <= '0;
      dm_q_q     <= '0;
      sat_q      <= 1'b0;
    end else begin
      dm_valid_q <= last_v;
      sat_q      <= last_v && (si_c[OUT_WIDTH] || sq_c[OUT_WIDTH]);
      if (last_v) begin
        dm_i_q <= si_c[OUT_WIDTH-1:0];
        dm_q_q <= sq_c[OUT_WIDTH-1:0];
      end
    end
  end

  assign dm_valid   = dm_valid_q;
  assign dm_i       = dm_i_q;
  assign dm_q       = dm_q_q;
  assign sat_flag   = sat_q;
  assign locked     = locked_q;
  assign fifo_level = count_q;
  assign fifo_ovf   = ovf_q;
  assign fifo_unf   = unf_q;

endmodule

// File: tb/tb_qam_demult_sync.sv
// Scoreboarded bench for qam_demult_sync with directed vectors.
module tb_qam_demult_sync;

  localparam int IW = 13;
  localparam int CW = 8;
  localparam int OW = 13;
  localparam int DEPTH = 64;
  localparam int ML = 4;
  localparam int LW = $clog2(DEPTH) + 1;

  logic axi_clk = 1'b0;
  logic axi_rstn;
  logic qam_valid;
  logic signed [IW-1:0] qam_data;
  logic car_valid, car_zero;
  logic signed [CW-1:0] car_sin, car_cos;
  logic resync_req, clr_flags;
  logic dm_valid;
  logic signed [OW-1:0] dm_i, dm_q;
  logic locked;
  logic [LW-1:0] fifo_level;
  logic fifo_ovf, fifo_unf, sat_flag;

  typedef struct {
    int i;
    int q;
    int sat;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  qam_demult_sync #(
    .IN_WIDTH(IW), .CAR_WIDTH(CW), .OUT_WIDTH(OW),
    .FIFO_DEPTH(DEPTH), .MULT_LATENCY(ML), .ROUND_MODE(0)
  ) dut (
    .axi_clk(axi_clk), .axi_rstn(axi_rstn),
    .qam_valid(qam_valid), .qam_data(qam_data),
    .car_valid(car_valid), .car_zero(car_zero),
    .car_sin(car_sin), .car_cos(car_cos),
    .resync_req(resync_req), .clr_flags(clr_flags),
    .dm_valid(dm_valid), .dm_i(dm_i), .dm_q(dm_q),
    .locked(locked), .fifo_level(fifo_level),
    .fifo_ovf(fifo_ovf), .fifo_unf(fifo_unf), .sat_flag(sat_flag)
  );

  always #5 axi_clk = ~axi_clk;

  task automatic chk(input string name, input logic signed [31:0] act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input int q, input int sat);
    exp_t e;
    e.i = i;
    e.q = q;
    e.sat = sat;
    sb.push_back(e);
  endtask

  task automatic drive(input bit qv, input int qd, input bit cv, input bit cz,
                       input int s, input int c);
    qam_valid = qv;
    qam_data  = IW'(qd);
    car_valid = cv;
    car_zero  = cz;
    car_sin   = CW'(s);
    car_cos   = CW'(c);
  endtask

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dm_valid"}, 32'(dm_valid), 0);
    chk({tag, "_dm_i"}, 32'(dm_i), 0);
    chk({tag, "_dm_q"}, 32'(dm_q), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_level"}, 32'(fifo_level), 0);
    chk({tag, "_ovf"}, 32'(fifo_ovf), 0);
    chk({tag, "_unf"}, 32'(fifo_unf), 0);
    chk({tag, "_sat"}, 32'(sat_flag), 0);
  endtask

  // Monitor: every output strobe is matched against the next expected entry
  always @(negedge axi_clk) begin : monitor
    exp_t e;
    if (axi_rstn === 1'b1) begin
      if (dm_valid === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: dm_i=%0d dm_q=%0d with nothing expected at %0t",
                   dm_i, dm_q, $time);
        end else begin
          e = sb.pop_front();
          chk("sb_dm_i", 32'(dm_i), e.i);
          chk("sb_dm_q", 32'(dm_q), e.q);
          chk("sb_sat_flag", 32'(sat_flag), e.sat);
        end
      end else if (sat_flag !== 1'b0) begin
        tests++;
        fails++;
        $display("FAIL sat_without_valid: sat_flag=%b, expected 0 at %0t", sat_flag, $time);
      end
    end
  end

  int six[10] = '{-3, -100, 1000, 7, 11, 12, 13, 14, 15, 16};

  initial begin
    axi_rstn   = 1'b0;
    resync_req = 1'b0;
    clr_flags  = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge axi_clk);
    #1;
    chk_all_zero("reset");
    axi_rstn = 1'b1;
    tick();

    // Buffer three samples while the carrier never hits zero phase
    drive(1, 256, 1, 0, 0, 127); tick();
    drive(1, 100, 1, 0, 0, 127); tick();
    drive(1, 3,   1, 0, 0, 127); tick();
    chk("t1_level", 32'(fifo_level), 3);
    chk("t1_locked", 32'(locked), 0);
    chk("t1_dm_valid", 32'(dm_valid), 0);

    // Zero-phase lock then run until empty
    push(254, 0, 0);
    push(99, 0, 0);
    push(1, 0, 0);
    drive(0, 0, 1, 1, 0, 127); tick();
    chk("t2_locked", 32'(locked), 1);
    chk("t2_level", 32'(fifo_level), 2);
    drive(0, 0, 1, 0, 0, 127); tick();
    chk("t2_lat1", 32'(dm_valid), 0);
    drive(0, 0, 1, 0, 0, 64); tick();
    chk("t2_lat2", 32'(dm_valid), 0);
    chk("t2_level0", 32'(fifo_level), 0);
    drive(0, 0, 1, 0, 0, 0); tick();
    chk("t5_unlock", 32'(locked), 0);
    chk("t5_unf", 32'(fifo_unf), 1);
    chk("t2_lat3", 32'(dm_valid), 0);
    tick();
    chk("t2_lat4_valid", 32'(dm_valid), 1);
    tick(); tick(); tick();
    chk("t2_valid_low", 32'(dm_valid), 0);
    chk("t2_hold_i", 32'(dm_i), 1);

    // After underflow the next read waits for zero phase
    drive(1, -4096, 1, 0, 0, 127); tick();
    drive(0, 0, 1, 0, 0, 127); tick(); tick();
    chk("t5_wait_level", 32'(fifo_level), 1);
    chk("t5_wait_locked", 32'(locked), 0);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    chk("t5_clr_unf", 32'(fifo_unf), 0);

    // Saturating I, exact -(-128) on Q
    push(4095, -4096, 1);
    drive(0, 0, 1, 1, -128, -128); tick();
    chk("t3_locked", 32'(locked), 1);
    drive(0, 0, 0, 0, 0, 0); tick();
    chk("t3_drop_lock", 32'(locked), 0);
    chk("t3_no_unf", 32'(fifo_unf), 0);
    repeat (6) tick();

    // Fill, overflow, simultaneous read+write when full, clear
    for (int k = 0; k < DEPTH; k++) begin
      drive(1, k + 1, 0, 0, 0, 0); tick();
    end
    chk("t4_full_level", 32'(fifo_level), 64);
    chk("t4_no_ovf", 32'(fifo_ovf), 0);
    drive(1, 77, 0, 0, 0, 0); tick();
    chk("t4_ovf", 32'(fifo_ovf), 1);
    chk("t4_ovf_level", 32'(fifo_level), 64);
    push(-1, -1, 0);
    drive(1, 500, 1, 1, 127, -128); tick();
    chk("t4_rw_level", 32'(fifo_level), 64);
    chk("t4_rw_ovf", 32'(fifo_ovf), 1);
    chk("t4_rw_locked", 32'(locked), 1);
    clr_flags = 1'b1;
    drive(0, 0, 0, 0, 0, 0); tick();
    clr_flags = 1'b0;
    chk("t4_clr_ovf", 32'(fifo_ovf), 0);
    chk("t4_clr_locked", 32'(locked), 0);
    chk("t4_clr_level", 32'(fifo_level), 64);
    resync_req = 1'b1;
    drive(1, 999, 0, 0, 0, 0); tick();
    resync_req = 1'b0;
    chk("t4_flush_level", 32'(fifo_level), 0);
    drive(0, 0, 0, 0, 0, 0);
    repeat (6) tick();

    // Resync while running: in-flight samples still drain
    for (int k = 0; k < 10; k++) begin
      drive(1, six[k], 0, 0, 0, 0); tick();
    end
    chk("t6_level10", 32'(fifo_level), 10);
    push(-3, 2, 0);
    drive(0, 0, 1, 1, 127, 127); tick();
    chk("t6_locked", 32'(locked), 1);
    push(-50, 50, 0);
    drive(0, 0, 1, 0, 64, 64); tick();
    push(0, 7, 0);
    drive(0, 0, 1, 0, -1, 0); tick();
    push(6, 7, 0);
    drive(1, 999, 1, 0, -128, 127);
    resync_req = 1'b1; tick(); resync_req = 1'b0;
    chk("t6_resync_level", 32'(fifo_level), 0);
    chk("t6_resync_locked", 32'(locked), 0);
    drive(0, 0, 0, 0, 0, 0);
    repeat (8) tick();
    chk("t6_sb_drained", sb.size(), 0);

    // Reset mid-stream discards buffered and in-flight samples
    drive(1, 20, 0, 0, 0, 0); tick();
    drive(1, 21, 0, 0, 0, 0); tick();
    drive(1, 22, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 1, 0, 127); tick();
    drive(0, 0, 1, 0, 0, 127); tick(); tick();
    #2;
    axi_rstn = 1'b0;
    #1;
    chk_all_zero("midrst");
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge axi_clk);
    #1;
    axi_rstn = 1'b1;
    repeat (10) tick();
    chk("midrst_no_valid", 32'(dm_valid), 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/qam_demult_sync.md
Name: qam_demult_sync

Overview:
Parametrised carrier-synchronised QAM demultiplier for the receive path. It sits between the ADC/qam sample stream and the I/Q low-pass filters, and replaces the fixed-width demultiplier.
- Buffers incoming samples in an internal FIFO.
- Starts reading only on a carrier zero-phase cycle.
- Multiplies each sample by cos and −sin through a configurable pipeline.
- Delivers scaled, optionally rounded, saturated I/Q with lock and error status.

Parameters:
IN_WIDTH, 13, signed qam sample width
CAR_WIDTH, 8, signed carrier width; carrier is Q1.(CAR_WIDTH-1)
OUT_WIDTH, 13, signed I/Q output width
FIFO_DEPTH, 64, sample buffer depth; power of 2, ≥4
MULT_LATENCY, 4, multiplier pipeline stages, ≥1
ROUND_MODE, 0, 0 = truncate (arithmetic shift), 1 = round half up

Ports:
axi_clk  in  1  clock
axi_rstn  in  1  asynchronous active-low reset
qam_valid  in  1  input sample strobe
qam_data  in  IN_WIDTH  signed input sample
car_valid  in  1  carrier valid
car_zero  in  1  carrier at zero phase this cycle
car_sin  in  CAR_WIDTH  signed sine
car_cos  in  CAR_WIDTH  signed cosine
resync_req  in  1  pulse: flush FIFO, drop lock
clr_flags  in  1  pulse: clear sticky flags
dm_valid  out  1  output sample strobe
dm_i  out  OUT_WIDTH  signed I = sat(data·cos >>> (CAR_WIDTH-1))
dm_q  out  OUT_WIDTH  signed Q = sat(data·(−sin) >>> (CAR_WIDTH-1))
locked  out  1  FSM in RUN
fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
fifo_ovf  out  1  sticky: write dropped, FIFO full
fifo_unf  out  1  sticky: FIFO empty while RUN
sat_flag  out  1  1-cycle pulse with dm_valid when either channel saturated

Behaviour:
- Reset (async assert, sync release): FSM=WAIT_ZERO, FIFO empty, pipeline valids cleared. All outputs 0. Reset mid-operation discards buffered and in-flight samples.
- FIFO write: when qam_valid && (!full || rd_en).
  - qam_valid && full && !rd_en: sample dropped, fifo_ovf set.
  - Simultaneous read and write when full: both succeed, level unchanged.
  - Write when empty: accepted, no read this cycle.
- rd_en = car_valid && !empty && (state==RUN || (state==WAIT_ZERO && car_zero)).
- Read pairing: a sample read in cycle t is paired with car_sin/car_cos sampled in cycle t; the carrier is registered alongside the read. The first sample after lock is therefore multiplied by the zero-phase carrier.
- FSM WAIT_ZERO:
  - → RUN when car_valid && car_zero && !empty.
  - car_zero while empty: stay in WAIT_ZERO, no read.
- FSM RUN (locked=1):
  - → WAIT_ZERO on !car_valid; no read that cycle.
  - → WAIT_ZERO when car_valid && empty; set fifo_unf.
- resync_req: highest priority. FIFO flushed (level=0) and FSM→WAIT_ZERO next cycle. A qam write in the same cycle is discarded. Pipeline continues draining.
- Arithmetic:
  - −sin formed at CAR_WIDTH+1 bits, so −(−2^(CAR_WIDTH-1)) is exact.
  - Products are IN_WIDTH+CAR_WIDTH+1 bits, signed.
  - ROUND_MODE=1 adds 2^(CAR_WIDTH-2) before the shift.
  - Saturation clamps to [−2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)−1].
- Latency: dm_valid rises exactly 1+MULT_LATENCY cycles after the rd_en cycle. Throughput is 1 sample/cycle. dm_i/dm_q hold their last value while dm_valid=0.
- clr_flags clears fifo_ovf and fifo_unf. If clr_flags coincides with a new event, the set wins.

Test Plan:
1. Reset, write 3 samples (256, 100, 3) with car_valid=1 and car_zero=0 → locked=0, fifo_level=3, dm_valid stays 0.
2. From 1, pulse car_zero with cos=127, sin=0 → locked=1 that cycle+1. dm_valid pulses at +5, +6, +7 cycles. dm_i = 254, 99, 1 with ROUND_MODE=0. With ROUND_MODE=1 the third value is 2 (cos=64, data=3 gives 1.5). dm_q = 0 for all three.
3. data=−4096, cos=−128, sin=−128 (13/8/13 widths) → dm_i=4095 with sat_flag=1; dm_q=−4096 with no saturation on Q.
4. Write 65 samples with no read → the 65th is dropped, fifo_ovf=1, fifo_level=64. Next, write and read in the same cycle → level stays 64, fifo_ovf remains set. clr_flags → fifo_ovf=0.
5. In RUN, drain the FIFO until empty with car_valid=1 → fifo_unf=1 and locked=0. The next read waits for a car_zero cycle.
6. In RUN with 10 samples buffered, assert resync_req while qam_valid=1 → next cycle fifo_level=0 and locked=0. In-flight samples still emerge on dm_valid. Separately, assert axi_rstn low mid-stream → all outputs 0 immediately, with no further dm_valid.
